// File: rtl/wt_dcache_ship_tracker.sv
// Per-line SHiP metadata tracker: stores the fill signature, outcome bit and valid bit of every set/way.
// Latency: training pulses and the insertion hint are registered and appear 1 cycle after an event is accepted.
// Backpressure: req_ready_o is low only during the NumSets-cycle CLEAR walk. RUN accepts one event per cycle.
module wt_dcache_ship_tracker #(
  parameter int unsigned NumSets  = 256,
  parameter int unsigned NumWays  = 4,
  parameter int unsigned SigWidth = 14,
  localparam int unsigned IdxW    = $clog2(NumSets)
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  flush_i,
  input  logic                  req_valid_i,
  output logic                  req_ready_o,
  input  logic [1:0]            req_type_i,
  input  logic [IdxW-1:0]       req_idx_i,
  input  logic [1:0]            req_way_i,
  input  logic [SigWidth-1:0]   req_sig_i,
  output logic                  pred_hit_o,
  output logic [SigWidth-1:0]   pred_hit_shct_o,
  output logic                  pred_miss_o,
  output logic [4*SigWidth-1:0] pred_miss_shct_o,
  output logic [3:0]            pred_miss_way_o,
  output logic [3:0]            pred_outcome_o,
  output logic [SigWidth-1:0]   pred_shct_o,
  input  logic [1:0]            pred_result_i,
  output logic                  ins_hint_valid_o,
  output logic [1:0]            ins_hint_o
);

  localparam logic [1:0] REQ_HIT   = 2'd0;
  localparam logic [1:0] REQ_FILL  = 2'd1;
  localparam logic [1:0] REQ_INVAL = 2'd2;

  typedef enum logic {CLEAR, RUN} state_e;

  state_e                state_q;
  logic [IdxW-1:0]       clr_ptr_q;

  // Flop-based metadata arrays; contents are defined by the CLEAR walk, not by reset.
  logic [SigWidth-1:0]   sig_q     [NumSets][NumWays];
  logic [NumWays-1:0]    valid_q   [NumSets];
  logic [NumWays-1:0]    outcome_q [NumSets];

  logic                  acc;
  logic                  line_vld;
  logic [4*SigWidth-1:0] set_sigs;

  // Events arriving alongside reset or flush are dropped.
  assign req_ready_o = (state_q == RUN);
  assign acc         = req_valid_i && req_ready_o && !rst_i && !flush_i;
  assign pred_shct_o = (state_q == RUN) ? req_sig_i : '0;
  assign line_vld    = valid_q[req_idx_i][req_way_i];
  assign set_sigs    = {sig_q[req_idx_i][3], sig_q[req_idx_i][2],
                        sig_q[req_idx_i][1], sig_q[req_idx_i][0]};

  // Metadata update: the CLEAR walk wipes one set per cycle, and RUN applies accepted events.
  always_ff @(posedge clk_i) begin
    if (state_q == CLEAR) begin
      valid_q[clr_ptr_q]   <= '0;
      outcome_q[clr_ptr_q] <= '0;
      for (int w = 0; w < NumWays; w++) begin
        sig_q[clr_ptr_q][w] <= '0;
      end
    end else if (acc) begin
      case (req_type_i)
        REQ_HIT: begin
          if (line_vld) outcome_q[req_idx_i][req_way_i] <= 1'b1;
        end
        REQ_FILL: begin
          sig_q[req_idx_i][req_way_i]     <= req_sig_i;
          outcome_q[req_idx_i][req_way_i] <= 1'b0;
          valid_q[req_idx_i][req_way_i]   <= 1'b1;
        end
        REQ_INVAL: begin
          outcome_q[req_idx_i][req_way_i] <= 1'b0;
          valid_q[req_idx_i][req_way_i]   <= 1'b0;
        end
        default: ;
      endcase
    end
  end

  // Control FSM plus registered training and hint outputs.
  always_ff @(posedge clk_i) begin
    if (rst_i || flush_i) begin
      state_q          <= CLEAR;
      clr_ptr_q        <= '0;
      pred_hit_o       <= 1'b0;
      pred_hit_shct_o  <= '0;
      pred_miss_o      <= 1'b0;
      pred_miss_shct_o <= '0;
      pred_miss_way_o  <= '0;
      pred_outcome_o   <= '0;
      ins_hint_valid_o <= 1'b0;
      ins_hint_o       <= '0;
    end else begin
      pred_hit_o       <= 1'b0;
      pred_miss_o      <= 1'b0;
      ins_hint_valid_o <= 1'b0;
      case (state_q)
        CLEAR: begin
          clr_ptr_q <= clr_ptr_q + 1'b1;
          if (clr_ptr_q == IdxW'(NumSets - 1)) state_q <= RUN;
        end
        RUN: begin
          if (acc && req_type_i == REQ_HIT && line_vld) begin
            pred_hit_o      <= 1'b1;
            pred_hit_shct_o <= sig_q[req_idx_i][req_way_i];
          end
          if (acc && req_type_i == REQ_FILL) begin
            pred_miss_o      <= 1'b1;
            pred_miss_shct_o <= set_sigs;
            pred_miss_way_o  <= line_vld ? (4'b0001 << req_way_i) : 4'b0000;
            pred_outcome_o   <= outcome_q[req_idx_i];
            ins_hint_valid_o <= 1'b1;
            ins_hint_o       <= pred_result_i;
          end
        end
        default: state_q <= CLEAR;
      endcase
    end
  end

endmodule

// File: tb/tb_wt_dcache_ship_tracker.sv
module tb_wt_dcache_ship_tracker;

  localparam int NS = 256;
  localparam int SW = 14;

  logic          clk_i = 1'b0;
  logic          rst_i = 1'b0;
  logic          flush_i = 1'b0;
  logic          req_valid_i = 1'b0;
  logic          req_ready_o;
  logic [1:0]    req_type_i = 2'd0;
  logic [7:0]    req_idx_i = 8'd0;
  logic [1:0]    req_way_i = 2'd0;
  logic [SW-1:0] req_sig_i = '0;
  logic          pred_hit_o;
  logic [SW-1:0] pred_hit_shct_o;
  logic          pred_miss_o;
  logic [4*SW-1:0] pred_miss_shct_o;
  logic [3:0]    pred_miss_way_o;
  logic [3:0]    pred_outcome_o;
  logic [SW-1:0] pred_shct_o;
  logic [1:0]    pred_result_i = 2'd0;
  logic          ins_hint_valid_o;
  logic [1:0]    ins_hint_o;

  always #5 clk_i = ~clk_i;

  wt_dcache_ship_tracker #(.NumSets(NS), .NumWays(4), .SigWidth(SW)) dut (
    .clk_i(clk_i), .rst_i(rst_i), .flush_i(flush_i),
    .req_valid_i(req_valid_i), .req_ready_o(req_ready_o),
    .req_type_i(req_type_i), .req_idx_i(req_idx_i), .req_way_i(req_way_i),
    .req_sig_i(req_sig_i),
    .pred_hit_o(pred_hit_o), .pred_hit_shct_o(pred_hit_shct_o),
    .pred_miss_o(pred_miss_o), .pred_miss_shct_o(pred_miss_shct_o),
    .pred_miss_way_o(pred_miss_way_o), .pred_outcome_o(pred_outcome_o),
    .pred_shct_o(pred_shct_o), .pred_result_i(pred_result_i),
    .ins_hint_valid_o(ins_hint_valid_o), .ins_hint_o(ins_hint_o)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  typedef struct {
    logic [1:0]    typ;
    logic [7:0]    idx;
    logic [1:0]    way;
    logic [SW-1:0] sig;
    logic [1:0]    res;
    logic          hit;
    logic [SW-1:0] hit_shct;
    logic          miss;
    logic [3:0]    mway;
    logic [3:0]    outc;
    logic [4*SW-1:0] mshct;
  } vec_t;

  localparam logic [1:0] H = 2'd0, F = 2'd1, I = 2'd2, R = 2'd3;

  function automatic logic [4*SW-1:0] S(input logic [SW-1:0] w0, input logic [SW-1:0] w1,
                                       input logic [SW-1:0] w2, input logic [SW-1:0] w3);
    return {w3, w2, w1, w0};
  endfunction

  function automatic vec_t mk(input logic [1:0] typ, input logic [7:0] idx, input logic [1:0] way,
                              input logic [SW-1:0] sig, input logic [1:0] res,
                              input logic hit, input logic [SW-1:0] hshct,
                              input logic miss, input logic [3:0] mway, input logic [3:0] outc,
                              input logic [4*SW-1:0] mshct);
    vec_t v;
    v.typ = typ; v.idx = idx; v.way = way; v.sig = sig; v.res = res;
    v.hit = hit; v.hit_shct = hshct; v.miss = miss; v.mway = mway; v.outc = outc; v.mshct = mshct;
    return v;
  endfunction

  vec_t vt[17];

  // Issue one event at the negedge, check the combinational query, then check the registered outputs after the edge.
  task automatic apply(input vec_t v, input int n);
    @(negedge clk_i);
    req_valid_i = 1'b1; req_type_i = v.typ; req_idx_i = v.idx; req_way_i = v.way;
    req_sig_i = v.sig; pred_result_i = v.res;
    #1;
    chk($sformatf("v%0d ready", n), 64'(req_ready_o), 64'd1);
    chk($sformatf("v%0d pred_shct", n), 64'(pred_shct_o), 64'(v.sig));
    @(posedge clk_i);
    #1;
    req_valid_i = 1'b0;
    chk($sformatf("v%0d hit", n), 64'(pred_hit_o), 64'(v.hit));
    chk($sformatf("v%0d miss", n), 64'(pred_miss_o), 64'(v.miss));
    chk($sformatf("v%0d hint_vld", n), 64'(ins_hint_valid_o), 64'(v.miss));
    if (v.hit) chk($sformatf("v%0d hit_shct", n), 64'(pred_hit_shct_o), 64'(v.hit_shct));
    if (v.miss) begin
      chk($sformatf("v%0d miss_way", n), 64'(pred_miss_way_o), 64'(v.mway));
      chk($sformatf("v%0d outcome", n), 64'(pred_outcome_o), 64'(v.outc));
      chk($sformatf("v%0d miss_shct", n), 64'(pred_miss_shct_o), 64'(v.mshct));
      chk($sformatf("v%0d hint", n), 64'(ins_hint_o), 64'(v.res));
    end
  endtask

  // Count cycles with ready low (bounded), checking that no pulse fires and the query output stays 0.
  task automatic wait_clear(input string name, input int limit, output int n);
    bit bad;
    n = 0;
    bad = 1'b0;
    req_sig_i = 14'h3FFF;
    while (!req_ready_o && n < limit) begin
      if ((pred_hit_o || pred_miss_o || ins_hint_valid_o || pred_shct_o != 0) && !bad) begin
        bad = 1'b1;
        chk({name, " quiet in CLEAR"}, 64'd1, 64'd0);
      end
      n++;
      @(posedge clk_i);
      #1;
    end
  endtask

  initial begin
    int n;

    vt[0]  = mk(F, 8'd5,   2'd2, 14'h1234, 2'd2, 0, 0, 1, 4'b0000, 4'b0000, S(0, 0, 0, 0));
    vt[1]  = mk(H, 8'd5,   2'd2, 14'h0000, 2'd0, 1, 14'h1234, 0, 0, 0, 0);
    vt[2]  = mk(F, 8'd5,   2'd2, 14'h0ABC, 2'd1, 0, 0, 1, 4'b0100, 4'b0100, S(0, 0, 14'h1234, 0));
    vt[3]  = mk(F, 8'd7,   2'd0, 14'd1,    2'd3, 0, 0, 1, 4'b0000, 4'b0000, S(0, 0, 0, 0));
    vt[4]  = mk(F, 8'd7,   2'd1, 14'd2,    2'd0, 0, 0, 1, 4'b0000, 4'b0000, S(1, 0, 0, 0));
    vt[5]  = mk(F, 8'd7,   2'd2, 14'd3,    2'd1, 0, 0, 1, 4'b0000, 4'b0000, S(1, 2, 0, 0));
    vt[6]  = mk(F, 8'd7,   2'd3, 14'd4,    2'd2, 0, 0, 1, 4'b0000, 4'b0000, S(1, 2, 3, 0));
    vt[7]  = mk(F, 8'd7,   2'd0, 14'd5,    2'd2, 0, 0, 1, 4'b0001, 4'b0000, S(1, 2, 3, 4));
    vt[8]  = mk(H, 8'd7,   2'd3, 14'd0,    2'd0, 1, 14'd4, 0, 0, 0, 0);
    vt[9]  = mk(F, 8'd7,   2'd3, 14'd6,    2'd3, 0, 0, 1, 4'b1000, 4'b1000, S(5, 2, 3, 4));
    vt[10] = mk(H, 8'd9,   2'd1, 14'd0,    2'd0, 0, 0, 0, 0, 0, 0);
    vt[11] = mk(I, 8'd5,   2'd2, 14'd0,    2'd0, 0, 0, 0, 0, 0, 0);
    vt[12] = mk(H, 8'd5,   2'd2, 14'd0,    2'd0, 0, 0, 0, 0, 0, 0);
    vt[13] = mk(F, 8'd5,   2'd2, 14'd7,    2'd0, 0, 0, 1, 4'b0000, 4'b0000, S(0, 0, 14'h0ABC, 0));
    vt[14] = mk(R, 8'd5,   2'd2, 14'd9,    2'd3, 0, 0, 0, 0, 0, 0);
    vt[15] = mk(H, 8'd5,   2'd2, 14'd0,    2'd0, 1, 14'd7, 0, 0, 0, 0);
    vt[16] = mk(H, 8'd255, 2'd3, 14'd0,    2'd0, 0, 0, 0, 0, 0, 0);

    // Reset, then CLEAR must hold ready low for exactly NumSets cycles.
    @(negedge clk_i);
    rst_i = 1'b1;
    req_valid_i = 1'b1; req_type_i = F;
    @(posedge clk_i);
    #1;
    rst_i = 1'b0;
    req_valid_i = 1'b0;
    chk("reset ready", 64'(req_ready_o), 64'd0);
    chk("reset miss_shct", 64'(pred_miss_shct_o), 64'd0);
    chk("reset hint", 64'(ins_hint_o), 64'd0);
    wait_clear("reset", 400, n);
    chk("reset clear cycles", 64'(n), 64'(NS));

    for (int k = 0; k < 17; k++) apply(vt[k], k);

    // Idle cycle after the last hit: pulse drops, data holds.
    @(posedge clk_i);
    #1;
    chk("idle hit low", 64'(pred_hit_o), 64'd0);
    chk("idle hit_shct hold", 64'(pred_hit_shct_o), 64'd7);
    chk("idle hint hold", 64'(ins_hint_o), 64'd0);

    // Flush with a concurrent FILL: the event is dropped and outputs clear.
    @(negedge clk_i);
    flush_i = 1'b1;
    req_valid_i = 1'b1; req_type_i = F; req_idx_i = 8'd7; req_way_i = 2'd1; req_sig_i = 14'h155;
    pred_result_i = 2'd3;
    @(posedge clk_i);
    #1;
    flush_i = 1'b0;
    req_valid_i = 1'b0;
    chk("flush miss", 64'(pred_miss_o), 64'd0);
    chk("flush hint_vld", 64'(ins_hint_valid_o), 64'd0);
    chk("flush hit_shct zero", 64'(pred_hit_shct_o), 64'd0);
    chk("flush ready", 64'(req_ready_o), 64'd0);

    // Flush again partway through CLEAR: the walk restarts from set 0.
    wait_clear("flush1", 100, n);
    chk("flush partial cycles", 64'(n), 64'd100);
    @(negedge clk_i);
    flush_i = 1'b1;
    @(posedge clk_i);
    #1;
    flush_i = 1'b0;
    wait_clear("flush2", 400, n);
    chk("flush restart cycles", 64'(n), 64'(NS));

    // Previously valid lines are now invalid with cleared signatures.
    apply(mk(F, 8'd5, 2'd2, 14'h22, 2'd1, 0, 0, 1, 4'b0000, 4'b0000, S(0, 0, 0, 0)), 100);
    apply(mk(F, 8'd7, 2'd0, 14'h33, 2'd2, 0, 0, 1, 4'b0000, 4'b0000, S(0, 0, 0, 0)), 101);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: simulation did not finish, expected completion");
    $fatal(1);
  end

endmodule
